// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-command responder.
package mem_bus_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 16;
    localparam int RAM_DEPTH = 256;

    localparam logic [ADDR_W-1:0] LED_ADDR_DEF = 9'h100;
    localparam logic [ADDR_W-1:0] SW_ADDR_DEF  = 9'h140;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10,
        MILL   = 2'b11
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_NONE
    } addr_sel_t;

    function automatic addr_sel_t decode(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] led_addr,
                                         input logic [ADDR_W-1:0] sw_addr);
        if (!addr[ADDR_W-1])    return SEL_RAM;
        if (addr == led_addr)   return SEL_LED;
        if (addr == sw_addr)    return SEL_SW;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/mem_ram_1p.sv
// 256x16 single-port data RAM: synchronous write, combinational read, no reset.
module mem_ram_1p
    import mem_bus_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [7:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-command target: decodes RAM/LED/switch space, inserts wait states,
// returns a one-cycle response pulse.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR    = LED_ADDR_DEF,
    parameter logic [ADDR_W-1:0] SW_ADDR     = SW_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic [1:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out
);

    localparam logic [2:0] LAST = 3'(WAIT_CYCLES - 1);

    resp_state_t       state;
    logic [2:0]        cnt;
    mem_cmd_t          cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        sw_meta, sw_sync;

    logic              accept, in_wait, go_resp, ram_we, rd_err;
    mem_cmd_t          eff_cmd;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_wdata, ram_rdata, rd_data;
    addr_sel_t         sel;

    assign accept = req_valid & req_ready & (req_cmd != MNONE);
    assign in_wait = (state == WAIT);

    // All side effects and read sampling happen on the edge entering RESP; with
    // zero wait states that edge is the accept edge, so the live bus is used.
    assign go_resp   = in_wait ? (cnt == LAST) : (accept && (WAIT_CYCLES == 0));
    assign eff_cmd   = in_wait ? cmd_q   : mem_cmd_t'(req_cmd);
    assign eff_addr  = in_wait ? addr_q  : req_addr;
    assign eff_wdata = in_wait ? wdata_q : req_wdata;
    assign sel       = decode(eff_addr, LED_ADDR, SW_ADDR);
    assign ram_we    = reset_n & go_resp & (eff_cmd == MWRITE) & (sel == SEL_RAM);

    mem_ram_1p u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (eff_addr[7:0]),
        .wdata (eff_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (eff_cmd)
            MREAD: begin
                case (sel)
                    SEL_RAM: rd_data = ram_rdata;
                    SEL_LED: rd_data = {8'h00, led_out};
                    SEL_SW:  rd_data = {8'h00, sw_sync};
                    default: rd_err  = 1'b1;
                endcase
            end
            MWRITE:  rd_err = (sel == SEL_SW) || (sel == SEL_NONE);
            default: rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_q     <= MNONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            led_out   <= '0;
        end else begin
            sw_meta   <= sw_in;
            sw_sync   <= sw_meta;
            rsp_valid <= go_resp;
            rsp_rdata <= go_resp ? rd_data : '0;
            rsp_err   <= go_resp & rd_err;

            if (go_resp && eff_cmd == MWRITE && sel == SEL_LED)
                led_out <= eff_wdata[7:0];

            if (accept) begin
                cmd_q   <= mem_cmd_t'(req_cmd);
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end

            case (state)
                IDLE, RESP: begin
                    if (accept && WAIT_CYCLES == 0) begin
                        state     <= RESP;
                        req_ready <= 1'b1;
                    end else if (accept) begin
                        state     <= WAIT;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == LAST) begin
                        state     <= RESP;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
